// File: rtl/qkv_row_loader.sv
`default_nettype none
// ============================================================================
// qkv_row_loader : streams Q, K, V rows into packed matrix buses, then kicks
//                  attention and holds the matrices until it reports done.
// Revision       : 1.0  initial release
// ============================================================================
module qkv_row_loader #(
  parameter int D_W = 16,
  parameter int DIM = 16,
  parameter int D_K = 16
) (
  input  logic                   I_CLK,
  input  logic                   I_SYNC_RST,
  input  logic                   I_ROW_VLD,
  output logic                   O_ROW_RDY,
  input  logic [D_K*D_W-1:0]     I_ROW_DATA,
  input  logic                   I_ATTN_DONE,
  output logic                   O_ATTN_START,
  output logic [DIM*D_K*D_W-1:0] O_MAT_Q,
  output logic [DIM*D_K*D_W-1:0] O_MAT_K,
  output logic [DIM*D_K*D_W-1:0] O_MAT_V,
  output logic                   O_BUSY
);

  localparam int ROW_W = D_K * D_W;
  localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIM - 1);

  typedef enum logic [2:0] {
    LOAD_Q    = 3'd0,
    LOAD_K    = 3'd1,
    LOAD_V    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             row_hs;
  logic             wr_q, wr_k, wr_v;

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q   <= LOAD_Q;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    O_ROW_RDY    = 1'b0;
    O_ATTN_START = 1'b0;
    O_BUSY       = 1'b0;
    case (state_q)
      LOAD_Q, LOAD_K, LOAD_V: begin
        O_ROW_RDY = 1'b1;
        if (I_ROW_VLD) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            case (state_q)
              LOAD_Q:  state_d = LOAD_K;
              LOAD_K:  state_d = LOAD_V;
              default: state_d = START;
            endcase
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      START: begin
        O_ATTN_START = 1'b1;
        O_BUSY       = 1'b1;
        state_d      = WAIT_DONE;
      end
      WAIT_DONE: begin
        O_BUSY = 1'b1;
        if (I_ATTN_DONE) begin
          state_d = LOAD_Q;
        end
      end
      default: begin
        state_d   = LOAD_Q;
        row_cnt_d = '0;
      end
    endcase
  end

  assign row_hs = I_ROW_VLD && O_ROW_RDY;
  assign wr_q   = row_hs && (state_q == LOAD_Q);
  assign wr_k   = row_hs && (state_q == LOAD_K);
  assign wr_v   = row_hs && (state_q == LOAD_V);

  // One row register per matrix row; only the row addressed by row_cnt_q loads.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    logic             row_sel;
    logic [ROW_W-1:0] q_row_q;
    logic [ROW_W-1:0] k_row_q;
    logic [ROW_W-1:0] v_row_q;

    assign row_sel = (row_cnt_q == CNT_W'(r));

    always_ff @(posedge I_CLK) begin
      if (I_SYNC_RST) begin
        q_row_q <= '0;
        k_row_q <= '0;
        v_row_q <= '0;
      end else begin
        if (wr_q && row_sel) q_row_q <= I_ROW_DATA;
        if (wr_k && row_sel) k_row_q <= I_ROW_DATA;
        if (wr_v && row_sel) v_row_q <= I_ROW_DATA;
      end
    end

    assign O_MAT_Q[r*ROW_W +: ROW_W] = q_row_q;
    assign O_MAT_K[r*ROW_W +: ROW_W] = k_row_q;
    assign O_MAT_V[r*ROW_W +: ROW_W] = v_row_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_qkv_row_loader.sv
`default_nettype none
// ============================================================================
// tb_qkv_row_loader : directed bench for qkv_row_loader.
// Revision          : 1.0  initial release
// ============================================================================
module tb_qkv_row_loader;

  localparam int D_W   = 16;
  localparam int DIM   = 16;
  localparam int D_K   = 16;
  localparam int ROW_W = D_K * D_W;
  localparam int MAT_W = DIM * ROW_W;
  localparam int NBEAT = 3 * DIM;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld;
  logic             done;
  logic [ROW_W-1:0] data;
  logic             rdy;
  logic             start;
  logic             busy;
  logic [MAT_W-1:0] mat_q, mat_k, mat_v;

  int total = 0;
  int bad   = 0;
  logic [MAT_W-1:0] exp_m [3];

  qkv_row_loader #(.D_W(D_W), .DIM(DIM), .D_K(D_K)) dut (
    .I_CLK       (clk),
    .I_SYNC_RST  (rst),
    .I_ROW_VLD   (vld),
    .O_ROW_RDY   (rdy),
    .I_ROW_DATA  (data),
    .I_ATTN_DONE (done),
    .O_ATTN_START(start),
    .O_MAT_Q     (mat_q),
    .O_MAT_K     (mat_k),
    .O_MAT_V     (mat_v),
    .O_BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D_W-1:0] elem(input int pat, input int m, input int r, input int c);
    case (pat)
      0:       return D_W'(c << 8);
      1:       return D_W'(((m + 1) << 12) | (r << 8) | c);
      default: return D_W'((r * D_K + c) * 37 + m * 911 + 5);
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input int pat, input int m, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < D_K; c++) v[c*D_W +: D_W] = elem(pat, m, r, c);
    return v;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk16(input string tag, input logic [D_W-1:0] obs, input logic [D_W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_mat(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] expv);
    int first;
    first = 0;
    total++;
    assert (obs === expv) else begin
      bad++;
      for (int e = DIM * D_K - 1; e >= 0; e--)
        if (obs[e*D_W +: D_W] !== expv[e*D_W +: D_W]) first = e;
      $error("FAIL %s elem(r=%0d,c=%0d) obs=%h exp=%h", tag, first / D_K, first % D_K,
             obs[first*D_W +: D_W], expv[first*D_W +: D_W]);
    end
  endtask

  task automatic chk_mats(input string tag);
    chk_mat({tag, "_q"}, mat_q, exp_m[0]);
    chk_mat({tag, "_k"}, mat_k, exp_m[1]);
    chk_mat({tag, "_v"}, mat_v, exp_m[2]);
  endtask

  task automatic clear_model();
    for (int m = 0; m < 3; m++) exp_m[m] = '0;
  endtask

  // Sends beats first_b..last_b of the Q,K,V order; optional idle cycle after each
  // beat, optional I_ATTN_DONE pulse alongside beat spur.
  task automatic load_beats(input int first_b, input int last_b, input int pat,
                            input bit bub, input int spur);
    for (int b = first_b; b <= last_b; b++) begin
      int m;
      int r;
      m = b / DIM;
      r = b % DIM;
      chk_bit("rdy_before_beat", rdy, 1'b1);
      vld  = 1'b1;
      data = row_of(pat, m, r);
      done = (b == spur);
      tick();
      vld  = 1'b0;
      done = 1'b0;
      exp_m[m][r*ROW_W +: ROW_W] = row_of(pat, m, r);
      if (b != NBEAT - 1) begin
        chk_bit("no_early_start", start, 1'b0);
        if (bub) begin
          data = {D_K{16'hbeef}};
          tick();
          chk_bit("no_start_bubble", start, 1'b0);
        end
      end
    end
  endtask

  task automatic finish_load(input string tag);
    chk_bit({tag, "_start"}, start, 1'b1);
    chk_bit({tag, "_busy"},  busy,  1'b1);
    chk_bit({tag, "_rdy"},   rdy,   1'b0);
    chk_mats(tag);
    tick();
    chk_bit({tag, "_start_once"}, start, 1'b0);
    chk_bit({tag, "_busy_wait"},  busy,  1'b1);
    chk_bit({tag, "_rdy_wait"},   rdy,   1'b0);
  endtask

  task automatic release_attn();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_bit("rdy_after_done",  rdy,   1'b1);
    chk_bit("busy_after_done", busy,  1'b0);
    chk_bit("start_after_done", start, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    done = 1'b0;
    data = '0;
    clear_model();

    // Reset held for 3 cycles
    tick(); tick(); tick();
    chk_bit("rst_start", start, 1'b0);
    chk_bit("rst_busy",  busy,  1'b0);
    chk_mats("rst");
    rst = 1'b0;
    tick();
    chk_bit("rel_rdy",   rdy,   1'b1);
    chk_bit("rel_busy",  busy,  1'b0);
    chk_bit("rel_start", start, 1'b0);

    // Full load with VLD held high, every row {c<<8}
    load_beats(0, NBEAT - 1, 0, 1'b0, -1);
    chk16("q_0_1",   mat_q[(0*D_K+1)*D_W +: D_W],   16'h0100);
    chk16("k_7_3",   mat_k[(7*D_K+3)*D_W +: D_W],   16'h0300);
    chk16("v_15_15", mat_v[(15*D_K+15)*D_W +: D_W], 16'h0f00);
    finish_load("full");

    // Hold-off: VLD high with junk while attention runs
    vld  = 1'b1;
    data = {D_K{16'hdead}};
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_bit("hold_rdy", rdy, 1'b0);
    end
    chk_bit("hold_busy", busy, 1'b1);
    vld = 1'b0;
    chk_mats("hold");
    release_attn();

    // Next beat writes Q row 0 only
    load_beats(0, 0, 1, 1'b0, -1);
    chk16("q_0_0_new", mat_q[0 +: D_W], 16'h1000);
    chk16("q_1_0_old", mat_q[(1*D_K)*D_W +: D_W], 16'h0000);
    chk_mats("q0_only");

    // Rest of load with bubbles and a spurious done at K row 5
    load_beats(1, NBEAT - 1, 1, 1'b1, DIM + 5);
    chk16("k_5_2_bub", mat_k[(5*D_K+2)*D_W +: D_W], 16'h2502);
    finish_load("bubble");
    tick();
    chk_bit("no_second_start", start, 1'b0);
    release_attn();

    // Mid-op reset after K row 7, with VLD high during reset
    load_beats(0, DIM + 7, 2, 1'b0, -1);
    rst  = 1'b1;
    vld  = 1'b1;
    data = row_of(2, 0, 0);
    tick();
    rst = 1'b0;
    vld = 1'b0;
    clear_model();
    chk_mats("midrst");
    chk_bit("midrst_busy", busy, 1'b0);
    chk_bit("midrst_rdy",  rdy,  1'b1);

    load_beats(0, NBEAT - 1, 2, 1'b0, -1);
    finish_load("fresh");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("fresh_single_start", start, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
